// File: rtl/rvfi_mem_mon_pkg.sv
// ----------------------------------------------------------------------------
// rvfi_mem_mon_pkg
// Shared types for the native valid/ready memory-interface monitor:
//   - mon_state_e : per-channel FSM state (IDLE / WAIT / ERR)
//   - WAIT_CNT_W  : width of the saturating stall counter
//   - TXN_CNT_W   : width of the wrapping handshake counter
//   - mem_req_t   : packed snapshot of one request {instr, addr, wdata, wstrb}
// The request struct is sized for the widest supported XLEN (64); narrower
// channels zero-extend into it, so one type serves every XLEN up to 64.
// ----------------------------------------------------------------------------
package rvfi_mem_mon_pkg;

    localparam int WAIT_CNT_W   = 8;
    localparam int TXN_CNT_W    = 16;
    localparam int MEM_XLEN_MAX = 64;
    localparam int MEM_STRB_MAX = MEM_XLEN_MAX / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } mon_state_e;

    typedef struct packed {
        logic                    instr;
        logic [MEM_XLEN_MAX-1:0] addr;
        logic [MEM_XLEN_MAX-1:0] wdata;
        logic [MEM_STRB_MAX-1:0] wstrb;
    } mem_req_t;

    function automatic mem_req_t pack_req(
        input logic                    instr,
        input logic [MEM_XLEN_MAX-1:0] addr,
        input logic [MEM_XLEN_MAX-1:0] wdata,
        input logic [MEM_STRB_MAX-1:0] wstrb
    );
        mem_req_t r;
        r.instr = instr;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        return r;
    endfunction

endpackage

// File: rtl/rvfi_mem_mon_chan.sv
// ----------------------------------------------------------------------------
// rvfi_mem_mon_chan
// Handshake monitor for a single valid/ready memory channel.
// Tracks the request through IDLE -> WAIT -> IDLE, counts stall cycles
// (saturating) and completed handshakes (wrapping), and raises sticky error
// flags for request instability, premature valid drop and stall timeout.
//
// Ports:
//   clk, resetn     clock, asynchronous active-low reset
//   check           enables error flag setting and ERR entry
//   mem_valid/ready request handshake
//   mem_instr/addr/wdata/wstrb  request fields (held stable while stalled)
//   wait_cnt        consecutive stall cycles, saturating at 255
//   stall_ok        1 while wait_cnt < MAX_WAIT
//   err_unstable    sticky: fields changed while stalled
//   err_drop        sticky: valid fell before ready
//   err_timeout     sticky: stall count exceeded MAX_WAIT
//   txn_cnt         completed handshakes, wrapping
// ----------------------------------------------------------------------------
module rvfi_mem_mon_chan
    import rvfi_mem_mon_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MAX_WAIT    = 5,
    parameter int CHECK_INSTR = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  check,
    input  logic                  mem_valid,
    input  logic                  mem_ready,
    input  logic                  mem_instr,
    input  logic [XLEN-1:0]       mem_addr,
    input  logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN/8-1:0]     mem_wstrb,
    output logic [WAIT_CNT_W-1:0] wait_cnt,
    output logic                  stall_ok,
    output logic                  err_unstable,
    output logic                  err_drop,
    output logic                  err_timeout,
    output logic [TXN_CNT_W-1:0]  txn_cnt
);

    localparam logic [WAIT_CNT_W:0] MAX_WAIT_EXT = (WAIT_CNT_W + 1)'(MAX_WAIT);

    function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    mon_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;
    logic [TXN_CNT_W-1:0]  txn_q, txn_d;
    logic                  unstable_q, unstable_d;
    logic                  drop_q, drop_d;
    logic                  timeout_q, timeout_d;
    logic                  capture_en;
    logic                  fields_differ;
    logic                  wait_over;
    logic                  instr_cmp;
    mem_req_t              cur_req;
    mem_req_t              cap_q;

    // With CHECK_INSTR=0 the instr bit is forced to 0 on both sides of the
    // comparison so it can never cause a mismatch.
    assign instr_cmp = (CHECK_INSTR != 0) ? mem_instr : 1'b0;

    assign cur_req = pack_req(instr_cmp,
                              MEM_XLEN_MAX'(mem_addr),
                              MEM_XLEN_MAX'(mem_wdata),
                              MEM_STRB_MAX'(mem_wstrb));

    assign fields_differ = (cur_req != cap_q);

    // Timeout looks at the registered count, so the flag rises on the edge
    // after wait_cnt has reached MAX_WAIT+1.
    assign wait_over = ({1'b0, wait_q} > MAX_WAIT_EXT);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        txn_d      = txn_q;
        unstable_d = unstable_q;
        drop_d     = drop_q;
        timeout_d  = timeout_q;
        capture_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (mem_ready) begin
                        txn_d = txn_q + 1'b1;
                    end else begin
                        state_d    = ST_WAIT;
                        capture_en = 1'b1;
                        wait_d     = WAIT_CNT_W'(1);
                    end
                end
            end

            ST_WAIT: begin
                if (check && wait_over) begin
                    timeout_d = 1'b1;
                end
                if (mem_valid) begin
                    // The accepting cycle is compared too: the request that
                    // completes must be the one that was first presented.
                    if (check && fields_differ) begin
                        unstable_d = 1'b1;
                    end
                    if (mem_ready) begin
                        state_d = ST_IDLE;
                        txn_d   = txn_q + 1'b1;
                        wait_d  = '0;
                    end else begin
                        wait_d = sat_inc(wait_q);
                    end
                end else if (check) begin
                    // Counters freeze at their values at the moment of the drop.
                    state_d = ST_ERR;
                    drop_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    wait_d  = '0;
                end
            end

            ST_ERR: begin
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            txn_q      <= '0;
            unstable_q <= 1'b0;
            drop_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            txn_q      <= txn_d;
            unstable_q <= unstable_d;
            drop_q     <= drop_d;
            timeout_q  <= timeout_d;
        end
    end

    // Captured request is pure data; it is only read in WAIT, which is always
    // entered through a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture_en) begin
            cap_q <= cur_req;
        end
    end

    assign wait_cnt     = wait_q;
    assign stall_ok     = ({1'b0, wait_q} < MAX_WAIT_EXT);
    assign err_unstable = unstable_q;
    assign err_drop     = drop_q;
    assign err_timeout  = timeout_q;
    assign txn_cnt      = txn_q;

endmodule

// File: rtl/rvfi_mem_handshake_monitor.sv
// ----------------------------------------------------------------------------
// rvfi_mem_handshake_monitor
// Multi-channel protocol monitor for the native valid/ready memory interface.
// One rvfi_mem_mon_chan per channel; channels are fully independent. The top
// only adds the registered OR of every sticky error flag.
//
// Ports (channel c occupies slice c of every packed vector):
//   clk, resetn   clock, asynchronous active-low reset
//   check         enables error flag setting
//   mem_valid     [NCHAN]          request valid
//   mem_ready     [NCHAN]          request accepted
//   mem_instr     [NCHAN]          instruction-fetch qualifier
//   mem_addr      [NCHAN*XLEN]     request address
//   mem_wdata     [NCHAN*XLEN]     write data
//   mem_wstrb     [NCHAN*XLEN/8]   write strobes
//   wait_cnt      [NCHAN*8]        consecutive stall count, saturating
//   stall_ok      [NCHAN]          fairness qualifier, wait_cnt < MAX_WAIT
//   err_unstable  [NCHAN]          sticky instability flag
//   err_drop      [NCHAN]          sticky premature-drop flag
//   err_timeout   [NCHAN]          sticky timeout flag
//   txn_cnt       [NCHAN*16]       completed handshakes, wrapping
//   any_err                        registered OR of all sticky flags
// ----------------------------------------------------------------------------
module rvfi_mem_handshake_monitor
    import rvfi_mem_mon_pkg::*;
#(
    parameter int NCHAN       = 1,
    parameter int XLEN        = 32,
    parameter int MAX_WAIT    = 5,
    parameter int CHECK_INSTR = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        check,
    input  logic [NCHAN-1:0]            mem_valid,
    input  logic [NCHAN-1:0]            mem_ready,
    input  logic [NCHAN-1:0]            mem_instr,
    input  logic [NCHAN*XLEN-1:0]       mem_addr,
    input  logic [NCHAN*XLEN-1:0]       mem_wdata,
    input  logic [NCHAN*XLEN/8-1:0]     mem_wstrb,
    output logic [NCHAN*WAIT_CNT_W-1:0] wait_cnt,
    output logic [NCHAN-1:0]            stall_ok,
    output logic [NCHAN-1:0]            err_unstable,
    output logic [NCHAN-1:0]            err_drop,
    output logic [NCHAN-1:0]            err_timeout,
    output logic [NCHAN*TXN_CNT_W-1:0]  txn_cnt,
    output logic                        any_err
);

    localparam int STRB_W = XLEN / 8;

    logic any_err_p1;

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        rvfi_mem_mon_chan #(
            .XLEN        (XLEN),
            .MAX_WAIT    (MAX_WAIT),
            .CHECK_INSTR (CHECK_INSTR)
        ) u_chan (
            .clk          (clk),
            .resetn       (resetn),
            .check        (check),
            .mem_valid    (mem_valid[c]),
            .mem_ready    (mem_ready[c]),
            .mem_instr    (mem_instr[c]),
            .mem_addr     (mem_addr[c*XLEN +: XLEN]),
            .mem_wdata    (mem_wdata[c*XLEN +: XLEN]),
            .mem_wstrb    (mem_wstrb[c*STRB_W +: STRB_W]),
            .wait_cnt     (wait_cnt[c*WAIT_CNT_W +: WAIT_CNT_W]),
            .stall_ok     (stall_ok[c]),
            .err_unstable (err_unstable[c]),
            .err_drop     (err_drop[c]),
            .err_timeout  (err_timeout[c]),
            .txn_cnt      (txn_cnt[c*TXN_CNT_W +: TXN_CNT_W])
        );
    end

    // Error summary register: any_err trails the per-channel flags by one cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            any_err_p1 <= 1'b0;
        end else begin
            any_err_p1 <= |{err_unstable, err_drop, err_timeout};
        end
    end

    assign any_err = any_err_p1;

endmodule

// File: tb/tb_rvfi_mem_handshake_monitor.sv
module tb_rvfi_mem_handshake_monitor;

    localparam int NCHAN    = 2;
    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 5;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic                    check;
    logic [NCHAN-1:0]        mem_valid;
    logic [NCHAN-1:0]        mem_ready;
    logic [NCHAN-1:0]        mem_instr;
    logic [NCHAN*XLEN-1:0]   mem_addr;
    logic [NCHAN*XLEN-1:0]   mem_wdata;
    logic [NCHAN*XLEN/8-1:0] mem_wstrb;
    logic [NCHAN*8-1:0]      wait_cnt;
    logic [NCHAN-1:0]        stall_ok;
    logic [NCHAN-1:0]        err_unstable;
    logic [NCHAN-1:0]        err_drop;
    logic [NCHAN-1:0]        err_timeout;
    logic [NCHAN*16-1:0]     txn_cnt;
    logic                    any_err;

    always #5 clk = ~clk;

    rvfi_mem_handshake_monitor #(
        .NCHAN       (NCHAN),
        .XLEN        (XLEN),
        .MAX_WAIT    (MAX_WAIT),
        .CHECK_INSTR (1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .check        (check),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_instr    (mem_instr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .wait_cnt     (wait_cnt),
        .stall_ok     (stall_ok),
        .err_unstable (err_unstable),
        .err_drop     (err_drop),
        .err_timeout  (err_timeout),
        .txn_cnt      (txn_cnt),
        .any_err      (any_err)
    );

    typedef struct {
        logic        rst_n;
        logic        chk;
        logic [1:0]  v;
        logic [1:0]  r;
        logic [31:0] a0;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [15:0] t0;
        logic [15:0] t1;
        logic [1:0]  so;
        logic [1:0]  eu;
        logic [1:0]  ed;
        logic [1:0]  et;
        logic        ae;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(int rst_n, int chk, int v, int r, int a0,
                                int w0, int w1, int t0, int t1,
                                int so, int eu, int ed, int et, int ae);
        vec_t x;
        x.rst_n = rst_n[0];
        x.chk   = chk[0];
        x.v     = v[1:0];
        x.r     = r[1:0];
        x.a0    = a0;
        x.w0    = w0[7:0];
        x.w1    = w1[7:0];
        x.t0    = t0[15:0];
        x.t1    = t1[15:0];
        x.so    = so[1:0];
        x.eu    = eu[1:0];
        x.ed    = ed[1:0];
        x.et    = et[1:0];
        x.ae    = ae[0];
        return x;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t x);
        cmp({tag, ".wait0"},    32'(wait_cnt[7:0]),   32'(x.w0));
        cmp({tag, ".wait1"},    32'(wait_cnt[15:8]),  32'(x.w1));
        cmp({tag, ".txn0"},     32'(txn_cnt[15:0]),   32'(x.t0));
        cmp({tag, ".txn1"},     32'(txn_cnt[31:16]),  32'(x.t1));
        cmp({tag, ".stall_ok"}, 32'(stall_ok),        32'(x.so));
        cmp({tag, ".unstable"}, 32'(err_unstable),    32'(x.eu));
        cmp({tag, ".drop"},     32'(err_drop),        32'(x.ed));
        cmp({tag, ".timeout"},  32'(err_timeout),     32'(x.et));
        cmp({tag, ".any_err"},  32'(any_err),         32'(x.ae));
    endtask

    task automatic apply(input vec_t x);
        resetn         = x.rst_n;
        check          = x.chk;
        mem_valid      = x.v;
        mem_ready      = x.r;
        mem_addr[31:0] = x.a0;
    endtask

    initial begin
        vec_t g;

        resetn    = 1'b0;
        check     = 1'b0;
        mem_valid = '0;
        mem_ready = '0;
        mem_instr = '0;
        mem_addr  = {32'h0000_0200, 32'h0};
        mem_wdata = {32'hCAFE_F00D, 32'hDEAD_BEEF};
        mem_wstrb = 8'hFF;

        //        rst chk v  r  addr0   w0 w1 t0 t1 so eu ed et ae
        // reset state
        vecs.push_back(mk(0, 0, 0, 0, 'h0,    0, 0, 0, 0, 3, 0, 0, 0, 0));
        // three back-to-back handshakes on channel 0
        vecs.push_back(mk(1, 1, 1, 1, 'h10,   0, 0, 1, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 'h10,   0, 0, 2, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 'h10,   0, 0, 3, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 'h10,   0, 0, 3, 0, 3, 0, 0, 0, 0));
        // stall exactly MAX_WAIT cycles: stall_ok drops, no timeout
        vecs.push_back(mk(1, 1, 1, 0, 'h20,   1, 0, 3, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 'h20,   2, 0, 3, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 'h20,   3, 0, 3, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 'h20,   4, 0, 3, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 'h20,   5, 0, 3, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 'h20,   0, 0, 4, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 'h20,   0, 0, 4, 0, 3, 0, 0, 0, 0));
        // stall MAX_WAIT+1 cycles: timeout the cycle after wait=6, any_err after that
        vecs.push_back(mk(1, 1, 1, 0, 'h30,   1, 0, 4, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 'h30,   2, 0, 4, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 'h30,   3, 0, 4, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 'h30,   4, 0, 4, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 'h30,   5, 0, 4, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 'h30,   6, 0, 4, 0, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 'h30,   0, 0, 5, 0, 3, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 'h30,   0, 0, 5, 0, 3, 0, 0, 1, 1));
        // address change while stalled with check=0: no flag
        vecs.push_back(mk(1, 0, 1, 0, 'h100,  1, 0, 5, 0, 3, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 'h100,  2, 0, 5, 0, 3, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 'h104,  3, 0, 5, 0, 3, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 1, 'h100,  0, 0, 6, 0, 3, 0, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 'h100,  0, 0, 6, 0, 3, 0, 0, 1, 1));
        // same with check=1: err_unstable
        vecs.push_back(mk(1, 1, 1, 0, 'h100,  1, 0, 6, 0, 3, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 'h100,  2, 0, 6, 0, 3, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 0, 'h104,  3, 0, 6, 0, 3, 1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 1, 'h100,  0, 0, 7, 0, 3, 1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 'h100,  0, 0, 7, 0, 3, 1, 0, 1, 1));
        // drop with check=0: back to IDLE, no flag, next handshake counts
        vecs.push_back(mk(1, 0, 1, 0, 'h40,   1, 0, 7, 0, 3, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 'h40,   0, 0, 7, 0, 3, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 1, 'h40,   0, 0, 8, 0, 3, 1, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 'h40,   0, 0, 8, 0, 3, 1, 0, 1, 1));
        // reset clears everything
        vecs.push_back(mk(0, 1, 0, 0, 'h0,    0, 0, 0, 0, 3, 0, 0, 0, 0));
        // channel 1 times out while channel 0 completes 4 handshakes
        vecs.push_back(mk(1, 1, 3, 1, 'h60,   0, 1, 1, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 1, 'h60,   0, 2, 2, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 1, 'h60,   0, 3, 3, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 1, 'h60,   0, 4, 4, 0, 3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 0, 'h60,   0, 5, 4, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 0, 'h60,   0, 6, 4, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 2, 2, 'h60,   0, 0, 4, 1, 3, 0, 0, 2, 0));
        vecs.push_back(mk(1, 1, 0, 0, 'h60,   0, 0, 4, 1, 3, 0, 0, 2, 1));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i]);
        end

        // Drop after two stall cycles with check=1: ERR, counters frozen
        g = mk(1, 1, 1, 0, 'h50, 1, 0, 4, 1, 3, 0, 0, 2, 1);
        apply(g);
        @(posedge clk); #1;
        check_outputs("drop.s1", g);
        g.w0 = 8'd2;
        @(posedge clk); #1;
        check_outputs("drop.s2", g);
        g.v  = 2'b00;
        g.ed = 2'b01;
        apply(g);
        @(posedge clk); #1;
        check_outputs("drop.err", g);
        g.v = 2'b01;
        g.r = 2'b01;
        apply(g);
        @(posedge clk); #1;
        check_outputs("drop.frozen", g);
        @(posedge clk); #1;
        check_outputs("drop.frozen2", g);

        // Asynchronous reset while in ERR: outputs clear with no clock edge
        #2;
        resetn = 1'b0;
        #1;
        g = mk(0, 1, 1, 1, 'h50, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        check_outputs("async_rst", g);

        // Channel leaves ERR after reset and counts again
        g = mk(1, 1, 1, 1, 'h50, 0, 0, 1, 0, 3, 0, 0, 0, 0);
        apply(g);
        @(posedge clk); #1;
        check_outputs("post_rst", g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
